// File: rtl/tt_window_filter_if.sv
// Bundle of the ingress beat stream, schedule-table push port, egress buffer
// stream and statistics outputs of tt_window_filter.
interface tt_window_filter_if #(
    parameter int DATA_W = 64,
    parameter int TIME_W = 64,
    parameter int PORTS  = 4,
    parameter int BUF_W  = 4
);
    logic [DATA_W-1:0] in_tt_data;
    logic [7:0]        in_tt_ctrl;
    logic              in_tt_wr;
    logic              out_tt_rdy;

    logic              in_table_wr;
    logic [TIME_W-1:0] in_window_start;
    logic [TIME_W-1:0] in_window_end;
    logic [15:0]       in_flow_id;
    logic [15:0]       in_tt_length;
    logic [15:0]       in_port_number;
    logic [BUF_W-1:0]  in_buffer_number;
    logic              out_table_rdy;

    logic [TIME_W-1:0] in_global_time;

    logic [DATA_W-1:0] out_buffer_data;
    logic [7:0]        out_buffer_ctrl;
    logic              out_buffer_wr;
    logic              in_buffer_rdy;
    logic [PORTS-1:0]  out_switch_port;
    logic [BUF_W-1:0]  out_switch_buffer;

    logic              out_miss;
    logic [15:0]       out_cnt_fwd;
    logic [15:0]       out_cnt_drop_time;
    logic [15:0]       out_cnt_drop_hdr;
    logic [15:0]       out_cnt_drop_nowin;
    logic [15:0]       out_cnt_miss;

    modport slave (
        input  in_tt_data, in_tt_ctrl, in_tt_wr,
        input  in_table_wr, in_window_start, in_window_end, in_flow_id,
        input  in_tt_length, in_port_number, in_buffer_number,
        input  in_global_time, in_buffer_rdy,
        output out_tt_rdy, out_table_rdy,
        output out_buffer_data, out_buffer_ctrl, out_buffer_wr,
        output out_switch_port, out_switch_buffer, out_miss,
        output out_cnt_fwd, out_cnt_drop_time, out_cnt_drop_hdr,
        output out_cnt_drop_nowin, out_cnt_miss
    );

    modport master (
        output in_tt_data, in_tt_ctrl, in_tt_wr,
        output in_table_wr, in_window_start, in_window_end, in_flow_id,
        output in_tt_length, in_port_number, in_buffer_number,
        output in_global_time, in_buffer_rdy,
        input  out_tt_rdy, out_table_rdy,
        input  out_buffer_data, out_buffer_ctrl, out_buffer_wr,
        input  out_switch_port, out_switch_buffer, out_miss,
        input  out_cnt_fwd, out_cnt_drop_time, out_cnt_drop_hdr,
        input  out_cnt_drop_nowin, out_cnt_miss
    );
endinterface

// File: rtl/tt_window_filter.sv
// Time-triggered receive-window filter: checks each TT frame against the head
// schedule entry and forwards accepted frames to the entry's port/buffer.
module tt_window_filter #(
    parameter int         DATA_W      = 64,
    parameter int         TIME_W      = 64,
    parameter int         PORTS       = 4,
    parameter int         BUF_W       = 4,
    parameter int         TABLE_DEPTH = 4,
    parameter int         OFFSET      = 10,
    parameter logic [7:0] EOP         = 8'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    tt_window_filter_if.slave   bus
);
    localparam int PTR_W = $clog2(TABLE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_CHECK, S_FWD0, S_FWD1, S_BODY, S_DROP
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [PORTS-1:0] port_onehot(input logic [15:0] pn);
        logic [PORTS-1:0] oh;
        oh = '0;
        for (int p = 0; p < PORTS; p++)
            if (pn == 16'(p + 1)) oh[p] = 1'b1;
        return oh;
    endfunction

    logic [TIME_W-1:0] tab_start [TABLE_DEPTH];
    logic [TIME_W-1:0] tab_end   [TABLE_DEPTH];
    logic [15:0]       tab_flow  [TABLE_DEPTH];
    logic [15:0]       tab_len   [TABLE_DEPTH];
    logic [PORTS-1:0]  tab_port  [TABLE_DEPTH];
    logic [BUF_W-1:0]  tab_buf   [TABLE_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              table_rdy_q;
    logic              push, pop, pop_exp, pop_fwd, empty, expire_hit;
    logic              tt_rdy, beat, is_eop;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] w0_q, w0_d, w1_q, w1_d;
    logic              hdr_eop_q, hdr_eop_d;
    logic [DATA_W-1:0] obuf_data_q, obuf_data_d;
    logic [7:0]        obuf_ctrl_q, obuf_ctrl_d;
    logic              obuf_wr_q, obuf_wr_d;
    logic [PORTS-1:0]  sw_port_q, sw_port_d;
    logic [BUF_W-1:0]  sw_buf_q, sw_buf_d;
    logic              miss_q;
    logic              inc_fwd, inc_time, inc_hdr, inc_nowin;
    logic [15:0]       cnt_fwd_q, cnt_time_q, cnt_hdr_q, cnt_nowin_q, cnt_miss_q;

    logic [TIME_W-1:0] ts, head_start, head_end;
    logic [15:0]       hdr_flow, hdr_len;
    logic [TIME_W:0]   expire_at;

    assign ts         = w0_q[TIME_W-1:0];
    assign hdr_flow   = w1_q[DATA_W-1 -: 16];
    assign hdr_len    = w1_q[DATA_W-17 -: 16];
    assign head_start = tab_start[rd_ptr_q];
    assign head_end   = tab_end[rd_ptr_q];

    // One extra bit keeps end + OFFSET from wrapping near the top of time.
    assign expire_at  = {1'b0, head_end} + (TIME_W+1)'(OFFSET);
    assign empty      = (count_q == '0);
    assign expire_hit = !empty && ({1'b0, bus.in_global_time} >= expire_at);
    assign push       = bus.in_table_wr && table_rdy_q;
    assign pop        = pop_exp || pop_fwd;
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    assign is_eop     = (bus.in_tt_ctrl == EOP);
    assign beat       = bus.in_tt_wr && tt_rdy;

    always_comb begin
        case (state_q)
            S_IDLE, S_HDR1, S_DROP: tt_rdy = 1'b1;
            S_BODY:                 tt_rdy = bus.in_buffer_rdy;
            default:                tt_rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        hdr_eop_d   = hdr_eop_q;
        obuf_data_d = obuf_data_q;
        obuf_ctrl_d = obuf_ctrl_q;
        obuf_wr_d   = 1'b0;
        pop_exp     = 1'b0;
        pop_fwd     = 1'b0;
        inc_fwd     = 1'b0;
        inc_time    = 1'b0;
        inc_hdr     = 1'b0;
        inc_nowin   = 1'b0;
        // Route stays up through the frame and one extra cycle for the last registered beat.
        sw_port_d   = (state_q inside {S_FWD0, S_FWD1, S_BODY}) ? sw_port_q : '0;
        sw_buf_d    = (state_q inside {S_FWD0, S_FWD1, S_BODY}) ? sw_buf_q  : '0;
        case (state_q)
            S_IDLE: begin
                pop_exp = expire_hit;
                if (beat) begin
                    if (is_eop) inc_hdr = 1'b1;
                    else begin
                        w0_d    = bus.in_tt_data;
                        state_d = S_HDR1;
                    end
                end
            end
            S_HDR1: begin
                pop_exp = expire_hit;
                if (beat) begin
                    w1_d      = bus.in_tt_data;
                    hdr_eop_d = is_eop;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_DROP;
                if (hdr_eop_q) begin
                    inc_hdr = 1'b1;
                    state_d = S_IDLE;
                end else if (empty) begin
                    inc_nowin = 1'b1;
                end else if (ts < head_start || ts > head_end) begin
                    inc_time = 1'b1;
                end else if (hdr_flow != tab_flow[rd_ptr_q] || hdr_len != tab_len[rd_ptr_q]) begin
                    inc_hdr = 1'b1;
                end else begin
                    pop_fwd   = 1'b1;
                    inc_fwd   = 1'b1;
                    sw_port_d = tab_port[rd_ptr_q];
                    sw_buf_d  = tab_buf[rd_ptr_q];
                    if (bus.in_buffer_rdy) begin
                        obuf_data_d = w0_q;
                        obuf_ctrl_d = '0;
                        obuf_wr_d   = 1'b1;
                        state_d     = S_FWD1;
                    end else begin
                        state_d = S_FWD0;
                    end
                end
            end
            S_FWD0: begin
                if (bus.in_buffer_rdy) begin
                    obuf_data_d = w0_q;
                    obuf_ctrl_d = '0;
                    obuf_wr_d   = 1'b1;
                    state_d     = S_FWD1;
                end
            end
            S_FWD1: begin
                if (bus.in_buffer_rdy) begin
                    obuf_data_d = w1_q;
                    obuf_ctrl_d = '0;
                    obuf_wr_d   = 1'b1;
                    state_d     = S_BODY;
                end
            end
            S_BODY: begin
                if (beat) begin
                    obuf_data_d = bus.in_tt_data;
                    obuf_ctrl_d = bus.in_tt_ctrl;
                    obuf_wr_d   = 1'b1;
                    if (is_eop) state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (beat && is_eop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tab_start[wr_ptr_q] <= bus.in_window_start;
            tab_end[wr_ptr_q]   <= bus.in_window_end;
            tab_flow[wr_ptr_q]  <= bus.in_flow_id;
            tab_len[wr_ptr_q]   <= bus.in_tt_length;
            tab_port[wr_ptr_q]  <= port_onehot(bus.in_port_number);
            tab_buf[wr_ptr_q]   <= bus.in_buffer_number;
        end
        w0_q <= w0_d;
        w1_q <= w1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_eop_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            table_rdy_q <= 1'b1;
            obuf_data_q <= '0;
            obuf_ctrl_q <= '0;
            obuf_wr_q   <= 1'b0;
            sw_port_q   <= '0;
            sw_buf_q    <= '0;
            miss_q      <= 1'b0;
            cnt_fwd_q   <= '0;
            cnt_time_q  <= '0;
            cnt_hdr_q   <= '0;
            cnt_nowin_q <= '0;
            cnt_miss_q  <= '0;
        end else begin
            state_q     <= state_d;
            hdr_eop_q   <= hdr_eop_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            table_rdy_q <= (count_d != CNT_W'(TABLE_DEPTH));
            obuf_data_q <= obuf_data_d;
            obuf_ctrl_q <= obuf_ctrl_d;
            obuf_wr_q   <= obuf_wr_d;
            sw_port_q   <= sw_port_d;
            sw_buf_q    <= sw_buf_d;
            miss_q      <= pop_exp;
            if (inc_fwd)   cnt_fwd_q   <= sat_inc(cnt_fwd_q);
            if (inc_time)  cnt_time_q  <= sat_inc(cnt_time_q);
            if (inc_hdr)   cnt_hdr_q   <= sat_inc(cnt_hdr_q);
            if (inc_nowin) cnt_nowin_q <= sat_inc(cnt_nowin_q);
            if (pop_exp)   cnt_miss_q  <= sat_inc(cnt_miss_q);
        end
    end

    assign bus.out_tt_rdy         = tt_rdy;
    assign bus.out_table_rdy      = table_rdy_q;
    assign bus.out_buffer_data    = obuf_data_q;
    assign bus.out_buffer_ctrl    = obuf_ctrl_q;
    assign bus.out_buffer_wr      = obuf_wr_q;
    assign bus.out_switch_port    = sw_port_q;
    assign bus.out_switch_buffer  = sw_buf_q;
    assign bus.out_miss           = miss_q;
    assign bus.out_cnt_fwd        = cnt_fwd_q;
    assign bus.out_cnt_drop_time  = cnt_time_q;
    assign bus.out_cnt_drop_hdr   = cnt_hdr_q;
    assign bus.out_cnt_drop_nowin = cnt_nowin_q;
    assign bus.out_cnt_miss       = cnt_miss_q;
endmodule

// File: tb/tb_tt_window_filter.sv
// Bench for tt_window_filter: directed scenarios plus randomized frames checked
// against a queue-based model of the schedule table and frame outcomes.
module tb_tt_window_filter;
    localparam int DATA_W = 64;
    localparam int TIME_W = 64;
    localparam int PORTS  = 4;
    localparam int BUF_W  = 4;
    localparam int DEPTH  = 4;
    localparam int OFFSET = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    tt_window_filter_if #(.DATA_W(DATA_W), .TIME_W(TIME_W), .PORTS(PORTS), .BUF_W(BUF_W)) bus ();

    tt_window_filter #(
        .DATA_W(DATA_W), .TIME_W(TIME_W), .PORTS(PORTS), .BUF_W(BUF_W),
        .TABLE_DEPTH(DEPTH), .OFFSET(OFFSET), .EOP(8'd1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] s;
        logic [63:0] e;
        logic [15:0] id;
        logic [15:0] len;
        logic [15:0] port;
        logic [3:0]  bufn;
    } entry_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic [3:0]  port;
        logic [3:0]  bufn;
        int          cyc;
    } beat_t;

    entry_t mq[$];
    beat_t  exp_q[$];
    beat_t  got_q[$];
    int     gi = 0;
    int     miss_seen = 0;
    int     tests = 0;
    int     fails = 0;
    int     m_fwd = 0, m_time = 0, m_hdr = 0, m_nowin = 0, m_miss = 0;
    int     last_acc_cyc = 0;
    int     w1_cyc = 0;
    bit     tog_en = 1'b0;

    always @(negedge clk) begin
        if (bus.out_buffer_wr === 1'b1)
            got_q.push_back('{bus.out_buffer_data, bus.out_buffer_ctrl,
                              bus.out_switch_port, bus.out_switch_buffer, cyc});
        if (bus.out_miss === 1'b1) miss_seen <= miss_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_port(input logic [15:0] p);
        return (p >= 16'd1 && p <= 16'd4) ? (4'b0001 << (p - 16'd1)) : 4'b0000;
    endfunction

    function automatic logic [7:0] rnd_ctrl();
        logic [7:0] c;
        c = 8'($urandom());
        return (c == 8'd1) ? 8'd0 : c;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] c);
        bit ok;
        int n;
        bus.in_tt_data = d;
        bus.in_tt_ctrl = c;
        bus.in_tt_wr   = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.out_tt_rdy;
            tick();
            n++;
            if (tog_en) bus.in_buffer_rdy = !bus.in_buffer_rdy;
        end
        last_acc_cyc = cyc;
        chk("beat_accept", 64'(ok), 64'd1);
    endtask

    task automatic push_entry(input entry_t e);
        bit exp_ok;
        bit ok;
        exp_ok = (mq.size() < DEPTH);
        bus.in_table_wr      = 1'b1;
        bus.in_window_start  = e.s;
        bus.in_window_end    = e.e;
        bus.in_flow_id       = e.id;
        bus.in_tt_length     = e.len;
        bus.in_port_number   = e.port;
        bus.in_buffer_number = e.bufn;
        @(negedge clk);
        ok = bus.out_table_rdy;
        tick();
        bus.in_table_wr = 1'b0;
        chk("push_accept", 64'(ok), 64'(exp_ok));
        if (exp_ok) mq.push_back(e);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_cnt_fwd"},   64'(bus.out_cnt_fwd),        64'(m_fwd));
        chk({tag, "_cnt_time"},  64'(bus.out_cnt_drop_time),  64'(m_time));
        chk({tag, "_cnt_hdr"},   64'(bus.out_cnt_drop_hdr),   64'(m_hdr));
        chk({tag, "_cnt_nowin"}, 64'(bus.out_cnt_drop_nowin), 64'(m_nowin));
        chk({tag, "_cnt_miss"},  64'(bus.out_cnt_miss),       64'(m_miss));
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(got_q.size() - gi), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gi + i < got_q.size(); i++) begin
            chk({tag, "_data"}, got_q[gi+i].data, exp_q[i].data);
            chk({tag, "_ctrl"}, 64'(got_q[gi+i].ctrl), 64'(exp_q[i].ctrl));
            chk({tag, "_port"}, 64'(got_q[gi+i].port), 64'(exp_q[i].port));
            chk({tag, "_buf"},  64'(got_q[gi+i].bufn), 64'(exp_q[i].bufn));
        end
        gi = got_q.size();
        exp_q.delete();
    endtask

    // Model: a frame is judged against the oldest schedule entry still queued.
    task automatic send_frame(input string tag, input logic [63:0] ts, input logic [15:0] id,
                              input logic [15:0] len, input int nb, input bit tog);
        logic [63:0] w1, d;
        logic [7:0]  c;
        entry_t      h;
        bit          fwd;
        fwd = 1'b0;
        w1  = {id, len, 32'($urandom())};
        if (mq.size() == 0) m_nowin++;
        else begin
            h = mq[0];
            if (ts < h.s || ts > h.e) m_time++;
            else if (id != h.id || len != h.len) m_hdr++;
            else begin
                fwd = 1'b1;
                m_fwd++;
                mq.delete(0);
            end
        end
        if (fwd) begin
            exp_q.push_back('{ts, 8'd0, exp_port(h.port), h.bufn, 0});
            exp_q.push_back('{w1, 8'd0, exp_port(h.port), h.bufn, 0});
        end
        tog_en = tog;
        send_beat(ts, rnd_ctrl());
        send_beat(w1, rnd_ctrl());
        w1_cyc = last_acc_cyc;
        for (int i = 0; i < nb; i++) begin
            d = {$urandom(), $urandom()};
            c = (i == nb - 1) ? 8'd1 : rnd_ctrl();
            send_beat(d, c);
            if (fwd) exp_q.push_back('{d, c, exp_port(h.port), h.bufn, 0});
        end
        bus.in_tt_wr = 1'b0;
        tog_en = 1'b0;
        bus.in_buffer_rdy = 1'b1;
        repeat (5) tick();
        check_beats(tag);
        check_counters(tag);
        chk({tag, "_port_idle"}, 64'(bus.out_switch_port), 64'd0);
    endtask

    initial begin
        entry_t e1, e;
        int     gi0, m0;
        logic [63:0] ts;
        logic [15:0] id, len;

        bus.in_tt_data = '0;
        bus.in_tt_ctrl = '0;
        bus.in_tt_wr = 1'b0;
        bus.in_table_wr = 1'b0;
        bus.in_window_start = '0;
        bus.in_window_end = '0;
        bus.in_flow_id = '0;
        bus.in_tt_length = '0;
        bus.in_port_number = '0;
        bus.in_buffer_number = '0;
        bus.in_global_time = '0;
        bus.in_buffer_rdy = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_table_rdy", 64'(bus.out_table_rdy), 64'd1);
        chk("rst_buf_wr", 64'(bus.out_buffer_wr), 64'd0);
        chk("rst_buf_data", bus.out_buffer_data, 64'd0);
        chk("rst_port", 64'(bus.out_switch_port), 64'd0);
        chk("rst_miss", 64'(bus.out_miss), 64'd0);
        check_counters("rst");
        rst_n = 1'b1;
        tick();

        // Basic forward with header latency
        e1 = '{64'd100, 64'd200, 16'h0005, 16'h0040, 16'd2, 4'd3};
        push_entry(e1);
        gi0 = gi;
        send_frame("fwd1", 64'd150, 16'h0005, 16'h0040, 2, 1'b0);
        if (got_q.size() > gi0) begin
            chk("fwd1_latency", 64'(got_q[gi0].cyc), 64'(w1_cyc + 1));
            chk("fwd1_port_onehot", 64'(got_q[gi0].port), 64'b0010);
            chk("fwd1_bufidx", 64'(got_q[gi0].bufn), 64'd3);
        end
        send_frame("empty_nowin", 64'd150, 16'h0005, 16'h0040, 1, 1'b0);

        // Time drop keeps the entry, then expiry at end+OFFSET exactly
        push_entry(e1);
        send_frame("late", 64'd250, 16'h0005, 16'h0040, 2, 1'b0);
        m0 = miss_seen;
        bus.in_global_time = 64'd209;
        repeat (3) tick();
        chk("miss_before_bound", 64'(miss_seen - m0), 64'd0);
        bus.in_global_time = 64'd210;
        repeat (3) tick();
        chk("miss_pulse", 64'(miss_seen - m0), 64'd1);
        m_miss++;
        mq.delete(0);
        bus.in_global_time = 64'd0;
        check_counters("expire");
        send_frame("after_expire", 64'd150, 16'h0005, 16'h0040, 1, 1'b0);

        // Header mismatch, then a matching frame uses the retained entry
        push_entry(e1);
        send_frame("bad_id", 64'd150, 16'h0006, 16'h0040, 2, 1'b0);
        send_frame("bad_len", 64'd150, 16'h0005, 16'h0041, 2, 1'b0);
        send_frame("good_id", 64'd150, 16'h0005, 16'h0040, 2, 1'b0);

        // Inclusive window edges
        push_entry(e1);
        push_entry(e1);
        send_frame("ts_start", 64'd100, 16'h0005, 16'h0040, 1, 1'b0);
        send_frame("ts_end", 64'd200, 16'h0005, 16'h0040, 1, 1'b0);
        push_entry(e1);
        send_frame("ts_end_p1", 64'd201, 16'h0005, 16'h0040, 1, 1'b0);
        send_frame("ts_start_m1", 64'd99, 16'h0005, 16'h0040, 1, 1'b0);
        send_frame("ts_mid", 64'd120, 16'h0005, 16'h0040, 1, 1'b0);

        // Full table, ignored fifth push, forwarding frees a slot
        for (int k = 1; k <= 4; k++) begin
            e = '{64'(1000 * k), 64'(1000 * k + 500), 16'(k), 16'(16 + k), 16'(k), 4'(k)};
            push_entry(e);
        end
        chk("full_table_rdy", 64'(bus.out_table_rdy), 64'd0);
        push_entry('{64'd0, 64'd5000, 16'h00AA, 16'h00BB, 16'd1, 4'd9});
        send_frame("full_fwd1", 64'd1200, 16'd1, 16'd17, 2, 1'b0);
        chk("slot_freed_rdy", 64'(bus.out_table_rdy), 64'd1);
        send_frame("full_fwd2", 64'd2000, 16'd2, 16'd18, 1, 1'b0);
        send_frame("full_fwd3", 64'd3500, 16'd3, 16'd19, 1, 1'b0);
        send_frame("full_fwd4", 64'd4499, 16'd4, 16'd20, 1, 1'b0);
        send_frame("fifth_absent", 64'd100, 16'h00AA, 16'h00BB, 1, 1'b0);

        // Backpressure toggling over an 8-beat body
        push_entry('{64'd10, 64'd90, 16'h0033, 16'h0100, 16'd3, 4'd7});
        send_frame("toggle8", 64'd50, 16'h0033, 16'h0100, 8, 1'b1);

        // Expiry compare near the top of the time range must not wrap
        push_entry('{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFFB, 16'h0044, 16'h0010, 16'd4, 4'd1});
        m0 = miss_seen;
        bus.in_global_time = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) tick();
        chk("no_wrap_expiry", 64'(miss_seen - m0), 64'd0);
        bus.in_global_time = 64'd0;
        send_frame("top_fwd", 64'hFFFF_FFFF_FFFF_FFCE, 16'h0044, 16'h0010, 1, 1'b0);

        // Randomized frames against the model
        for (int it = 0; it < 25; it++) begin
            if (mq.size() == 0 || $urandom_range(0, 2) != 0) begin
                e.s    = 64'($urandom_range(0, 1500));
                e.e    = e.s + 64'($urandom_range(0, 200));
                e.id   = 16'($urandom_range(0, 3));
                e.len  = 16'($urandom());
                e.port = 16'($urandom_range(0, 5));
                e.bufn = 4'($urandom());
                push_entry(e);
            end
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                ts  = mq[0].s + 64'($urandom_range(0, 32'(mq[0].e - mq[0].s)));
                id  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : mq[0].id;
                len = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : mq[0].len;
            end else begin
                ts  = 64'($urandom_range(0, 2000));
                id  = 16'($urandom_range(0, 3));
                len = 16'($urandom());
            end
            send_frame("rand", ts, id, len, $urandom_range(1, 6), 1'($urandom()));
        end
        chk("rand_table_rdy", 64'(bus.out_table_rdy), 64'(mq.size() < DEPTH));

        // Reset in the middle of a forwarded body
        while (mq.size() > 0) send_frame("drain", mq[0].s, mq[0].id, mq[0].len, 1, 1'b0);
        push_entry('{64'd100, 64'd200, 16'h0009, 16'h0020, 16'd1, 4'd1});
        send_beat(64'd150, 8'd0);
        send_beat({16'h0009, 16'h0020, 32'h0}, 8'd0);
        send_beat(64'h1111, 8'd0);
        send_beat(64'h2222, 8'd0);
        bus.in_tt_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_buf_wr", 64'(bus.out_buffer_wr), 64'd0);
        chk("midrst_port", 64'(bus.out_switch_port), 64'd0);
        chk("midrst_bufidx", 64'(bus.out_switch_buffer), 64'd0);
        chk("midrst_table_rdy", 64'(bus.out_table_rdy), 64'd1);
        chk("midrst_tt_rdy", 64'(bus.out_tt_rdy), 64'd1);
        mq.delete();
        exp_q.delete();
        m_fwd = 0; m_time = 0; m_hdr = 0; m_nowin = 0; m_miss = 0;
        check_counters("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        gi = got_q.size();
        send_frame("post_rst_nowin", 64'd150, 16'h0009, 16'h0020, 2, 1'b0);
        push_entry('{64'd100, 64'd200, 16'h0009, 16'h0020, 16'd1, 4'd2});
        send_frame("post_rst_fwd", 64'd150, 16'h0009, 16'h0020, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
